// File: rtl/audio_pkg.sv
// Purpose: shared widths, age saturation limit and allocator FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package audio_pkg;

  localparam int KEYW_DEF = 4;
  localparam int INCW_DEF = 19;
  localparam int AGEW_DEF = 4;
  localparam int AGE_MAX  = (2 ** AGEW_DEF) - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

endpackage

// File: rtl/voice_slot.sv
// Purpose: one oscillator slot holding key, phase increment, gate and age.
// Latency: every control takes effect at the next clk edge.
// Backpressure: none; controls are single-cycle strobes from the allocator.
// Ports: flush (all off, highest priority), set (load key/inc, gate on, age 0),
//        clear (gate off, inc 0), age_tick (saturating age+1 while gated);
//        key/inc/gate/age expose the slot state.
module voice_slot
  import audio_pkg::*;
#(
  parameter int KEYW    = KEYW_DEF,
  parameter int INCW    = INCW_DEF,
  parameter int AGEW    = AGEW_DEF,
  parameter int AGE_LIM = AGE_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            set,
  input  logic            clear,
  input  logic            age_tick,
  input  logic [KEYW-1:0] set_key,
  input  logic [INCW-1:0] set_inc,
  output logic [KEYW-1:0] key,
  output logic [INCW-1:0] inc,
  output logic            gate,
  output logic [AGEW-1:0] age
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key  <= '0;
      inc  <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (flush) begin
      // Keys are kept: with every gate low they can never match again.
      inc  <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (set) begin
      key  <= set_key;
      inc  <= set_inc;
      gate <= 1'b1;
      age  <= '0;
    end else if (clear) begin
      inc  <= '0;
      gate <= 1'b0;
    end else if (age_tick && gate && (age != AGEW'(AGE_LIM))) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Purpose: assigns serialized note-on/off requests to NVOICES oscillator slots.
// Latency: handshake at edge T -> slot outputs update at edge T+NVOICES+1.
// Backpressure: note_ready only in IDLE with panic low; one request in flight.
// Ports: note_valid/note_ready handshake with note_on/note_key/note_inc;
//        voice_inc/voice_gate per-slot oscillator controls; drop pulses when a
//        note-on finds no slot; panic flushes every slot synchronously.
// Build option: define VOICE_STEAL_EN to steal the oldest slot instead of dropping.
module voice_allocator
  import audio_pkg::*;
#(
  parameter int NVOICES = 4,
  parameter int KEYW    = KEYW_DEF,
  parameter int INCW    = INCW_DEF,
  parameter int AGEW    = AGEW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    panic,
  input  logic                    note_valid,
  output logic                    note_ready,
  input  logic                    note_on,
  input  logic [KEYW-1:0]         note_key,
  input  logic [INCW-1:0]         note_inc,
  output logic [NVOICES*INCW-1:0] voice_inc,
  output logic [NVOICES-1:0]      voice_gate,
  output logic                    drop
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

`ifdef VOICE_STEAL_EN
  localparam logic STEAL_EN = 1'b1;
`else
  localparam logic STEAL_EN = 1'b0;
`endif

  logic [1:0]      state;
  logic [IW-1:0]   scan_idx;
  logic            lat_on;
  logic [KEYW-1:0] lat_key;
  logic [INCW-1:0] lat_inc;

  // Scan candidates: (a) matching gated key, (b) first free, (c) oldest gated.
  logic            match_vld, free_vld, old_vld;
  logic [IW-1:0]   match_idx, free_idx, old_idx;
  logic [AGEW-1:0] old_age;

  logic [KEYW-1:0] slot_key  [NVOICES];
  logic [INCW-1:0] slot_inc  [NVOICES];
  logic            slot_gate [NVOICES];
  logic [AGEW-1:0] slot_age  [NVOICES];

  logic            apply_go;
  logic            tgt_vld;
  logic [IW-1:0]   tgt_idx;

  assign note_ready = (state == ST_IDLE) && !panic;
  assign apply_go   = (state == ST_APPLY) && !panic;

  always_comb begin
    tgt_vld = 1'b0;
    tgt_idx = '0;
    if (match_vld) begin
      tgt_vld = 1'b1;
      tgt_idx = match_idx;
    end else if (free_vld) begin
      tgt_vld = 1'b1;
      tgt_idx = free_idx;
    end else if (STEAL_EN && old_vld) begin
      tgt_vld = 1'b1;
      tgt_idx = old_idx;
    end
  end

  // With stealing on, a full bank always yields slot (c), so this stays low.
  assign drop = apply_go && lat_on && !tgt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      scan_idx  <= '0;
      lat_on    <= 1'b0;
      lat_key   <= '0;
      lat_inc   <= '0;
      match_vld <= 1'b0;
      free_vld  <= 1'b0;
      old_vld   <= 1'b0;
      match_idx <= '0;
      free_idx  <= '0;
      old_idx   <= '0;
      old_age   <= '0;
    end else if (panic) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (note_valid) begin
            lat_on    <= note_on;
            lat_key   <= note_key;
            lat_inc   <= note_inc;
            match_vld <= 1'b0;
            free_vld  <= 1'b0;
            old_vld   <= 1'b0;
            scan_idx  <= '0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (slot_gate[scan_idx] && (slot_key[scan_idx] == lat_key) && !match_vld) begin
            match_vld <= 1'b1;
            match_idx <= scan_idx;
          end
          if (!slot_gate[scan_idx] && !free_vld) begin
            free_vld <= 1'b1;
            free_idx <= scan_idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (slot_gate[scan_idx] && (!old_vld || (slot_age[scan_idx] > old_age))) begin
            old_vld <= 1'b1;
            old_idx <= scan_idx;
            old_age <= slot_age[scan_idx];
          end
          if (scan_idx == IW'(NVOICES - 1)) begin
            state <= ST_APPLY;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_APPLY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NVOICES; i++) begin : g_slot
    logic set_s, clr_s, tick_s;

    assign set_s  = apply_go && lat_on && tgt_vld && (tgt_idx == IW'(i));
    assign tick_s = apply_go && lat_on && tgt_vld && (tgt_idx != IW'(i));
    assign clr_s  = apply_go && !lat_on && match_vld && (match_idx == IW'(i));

    voice_slot #(
      .KEYW    (KEYW),
      .INCW    (INCW),
      .AGEW    (AGEW),
      .AGE_LIM ((2 ** AGEW) - 1)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (panic),
      .set      (set_s),
      .clear    (clr_s),
      .age_tick (tick_s),
      .set_key  (lat_key),
      .set_inc  (lat_inc),
      .key      (slot_key[i]),
      .inc      (slot_inc[i]),
      .gate     (slot_gate[i]),
      .age      (slot_age[i])
    );

    assign voice_inc[i*INCW +: INCW] = slot_inc[i];
    assign voice_gate[i]             = slot_gate[i];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Purpose: scoreboard bench for voice_allocator (4 voices, 19-bit increments).
// Latency: each request expects its completion NVOICES+1 edges after handshake.
// Backpressure: requests are only driven while note_ready is high.
module tb_voice_allocator;

`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        panic = 1'b0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic        note_on = 1'b0;
  logic [3:0]  note_key = '0;
  logic [18:0] note_inc = '0;
  logic [75:0] voice_inc;
  logic [3:0]  voice_gate;
  logic        drop;

  typedef struct {
    int          id;
    logic [3:0]  gate;
    logic [75:0] inc;
    int          ndrop;
    bit          chk_lat;
    int          hs;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   drop_cnt = 0;
  int   req_id = 0;
  logic prev_ready = 1'b1;

  voice_allocator #(
    .NVOICES (4),
    .KEYW    (4),
    .INCW    (19),
    .AGEW    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .panic      (panic),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_on    (note_on),
    .note_key   (note_key),
    .note_inc   (note_inc),
    .voice_inc  (voice_inc),
    .voice_gate (voice_gate),
    .drop       (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d requests outstanding", expq.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [75:0] pk(input logic [18:0] s0, input logic [18:0] s1,
                                     input logic [18:0] s2, input logic [18:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  // Monitor: a rising note_ready marks the end of the oldest outstanding request.
  initial begin
    forever begin
      @(negedge clk);
      if (drop === 1'b1) drop_cnt++;
      if (note_ready === 1'b1 && prev_ready === 1'b0) begin
        if (expq.size() == 0) begin
          check("spurious completion (queue depth)", 128'(expq.size()), 128'd1);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check($sformatf("req%0d voice_gate", e.id), 128'(voice_gate), 128'(e.gate));
          check($sformatf("req%0d voice_inc", e.id), 128'(voice_inc), 128'(e.inc));
          check($sformatf("req%0d drop pulses", e.id), 128'(drop_cnt), 128'(e.ndrop));
          if (e.chk_lat)
            check($sformatf("req%0d latency", e.id), 128'(cyc - e.hs), 128'd5);
        end
        drop_cnt = 0;
      end
      prev_ready = note_ready;
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 60 && expq.size() != 0; k++) @(negedge clk);
    check("scoreboard drained", 128'(expq.size()), 128'd0);
  endtask

  task automatic send(input bit on, input logic [3:0] key, input logic [18:0] inc,
                      input logic [3:0] eg, input logic [75:0] ei, input int nd,
                      input bit chk_lat, input bit wait_done);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (note_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (note_ready !== 1'b1) check("note_ready wait", 128'(note_ready), 128'd1);
    note_valid = 1'b1;
    note_on    = on;
    note_key   = key;
    note_inc   = inc;
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    e.id      = req_id;
    e.gate    = eg;
    e.inc     = ei;
    e.ndrop   = nd;
    e.chk_lat = chk_lat;
    e.hs      = cyc;
    expq.push_back(e);
    req_id++;
    if (wait_done) wait_idle();
  endtask

  initial begin
    logic [18:0] s0;
    int          nd6;
    s0  = STEAL ? 19'h600 : 19'h100;
    nd6 = STEAL ? 0 : 1;

    // Reset and idle hold
    #1 rst_n = 1'b0;
    #1;
    check("reset note_ready", 128'(note_ready), 128'd1);
    check("reset voice_gate", 128'(voice_gate), 128'd0);
    check("reset voice_inc", 128'(voice_inc), 128'd0);
    check("reset drop", 128'(drop), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle hold note_ready", 128'(note_ready), 128'd1);
    check("idle hold voice_gate", 128'(voice_gate), 128'd0);
    check("idle hold voice_inc", 128'(voice_inc), 128'd0);

    // Fill slots 0..3
    send(1, 4'd1, 19'h100, 4'b0001, pk(19'h100, 0, 0, 0), 0, 1, 1);
    send(1, 4'd2, 19'h200, 4'b0011, pk(19'h100, 19'h200, 0, 0), 0, 1, 1);
    send(1, 4'd3, 19'h300, 4'b0111, pk(19'h100, 19'h200, 19'h300, 0), 0, 1, 1);
    send(1, 4'd4, 19'h400, 4'b1111, pk(19'h100, 19'h200, 19'h300, 19'h400), 0, 1, 1);
    // Retrigger key 2 in place
    send(1, 4'd2, 19'h555, 4'b1111, pk(19'h100, 19'h555, 19'h300, 19'h400), 0, 1, 1);
    // Bank full: slot 0 is oldest (age 4) -> steal, or drop
    send(1, 4'd5, 19'h600, 4'b1111, pk(s0, 19'h555, 19'h300, 19'h400), nd6, 1, 1);
    // Note-off present and absent
    send(0, 4'd3, 19'h7ff, 4'b1011, pk(s0, 19'h555, 0, 19'h400), 0, 1, 1);
    send(0, 4'd9, 19'h7ff, 4'b1011, pk(s0, 19'h555, 0, 19'h400), 0, 1, 1);
    // Zero-pitch note-on takes the freed slot 2
    send(1, 4'd3, 19'h0, 4'b1111, pk(s0, 19'h555, 0, 19'h400), 0, 1, 1);

    // Panic during the second SCAN cycle
    send(1, 4'd6, 19'h666, 4'b0000, '0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    panic = 1'b1;
    @(posedge clk);
    #1;
    check("panic note_ready", 128'(note_ready), 128'd0);
    check("panic voice_gate", 128'(voice_gate), 128'd0);
    check("panic voice_inc", 128'(voice_inc), 128'd0);
    @(negedge clk);
    panic = 1'b0;
    wait_idle();
    send(1, 4'd7, 19'h700, 4'b0001, pk(19'h700, 0, 0, 0), 0, 1, 1);

    // Async reset during the second SCAN cycle
    send(1, 4'd8, 19'h800, 4'b0000, '0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset note_ready", 128'(note_ready), 128'd1);
    check("mid reset voice_gate", 128'(voice_gate), 128'd0);
    check("mid reset voice_inc", 128'(voice_inc), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle();
    send(1, 4'd2, 19'h123, 4'b0001, pk(19'h123, 0, 0, 0), 0, 1, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
